clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Receive-side checker for divided clocks produced by the team's clock dividers (e.g. N=60 on clk_fpga).
- Synchronises an incoming slow clock (clk_in) into the clk_fpga domain and measures its period and high time in clk_fpga cycles.
- Flags whether the measured period is within tolerance of the expected divide ratio, and flags a stalled input.
- Sits beside the divider in bring-up/printbot timing logic as a self-check.

Parameters:
- WIDTH, 16, width of period/high-time counters and outputs.
- N_EXP, 60, expected period of clk_in in clk_fpga cycles.
- TOL, 1, allowed absolute deviation of period from N_EXP, in cycles (inclusive).
- TIMEOUT, 240, clk_fpga cycles without a clk_in rising edge before err_timeout asserts; must be > N_EXP and < 2^WIDTH.

Ports:
- clk_fpga  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- clk_in  input  1  divided clock under test; asynchronous to the sampling point.
- enable  input  1  1 = measure; 0 = return to IDLE and hold outputs.
- period  output  WIDTH  last measured period (cycles between synchronised rising edges).
- high_time  output  WIDTH  last measured high time (cycles clk_in sampled high within that period).
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- freq_ok  output  1  1 when |period - N_EXP| <= TOL for the last measurement.
- err_timeout  output  1  sticky stall flag.
- duty_ok  output  1  duty check result (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): period=0, high_time=0, meas_valid=0, freq_ok=0, err_timeout=0, duty_ok=0, FSM=IDLE, counters=0, sync flops=0.
- Synchroniser: 2-flop chain on clk_in, then one edge-detect flop. rise = s2 & ~s3. Latency from a clk_in edge to rise is 2-3 clk_fpga cycles; the latency is constant, so it cancels in period.
- FSM states:
  - IDLE: counters cleared. Go to ARM when enable=1.
  - ARM: wait for the first rise, with no output update. On rise, clear counters and go to MEASURE.
  - MEASURE: each cycle tot_cnt += 1; hi_cnt += 1 when s3=1. On rise:
    - period <= tot_cnt + 1 and high_time <= hi_cnt (hi_cnt excludes the rise cycle itself).
    - meas_valid pulses for 1 cycle, freq_ok and duty_ok update in the same cycle, and err_timeout clears.
    - Counters restart at 0 and the FSM stays in MEASURE (back-to-back measurement, no dead cycle).
- Timeout: in ARM or MEASURE, a separate idle counter counts cycles since the last rise (or since entering ARM). When it reaches TIMEOUT:
  - err_timeout <= 1 (sticky) and freq_ok <= 0.
  - FSM goes to ARM. period and high_time are held.
  - If rise and timeout occur in the same cycle, rise wins: the measurement completes and there is no timeout.
- Counters saturate at 2^WIDTH-1 and never wrap.
- enable=0 in any state: FSM goes to IDLE next cycle and the partial measurement is discarded. Outputs hold their last values, except that meas_valid is 0. err_timeout holds.
- Arithmetic: the deviation is computed unsigned as (period >= N_EXP) ? period-N_EXP : N_EXP-period, at WIDTH bits.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_CHECK_EN.
- Defined: duty_ok is registered with meas_valid and equals 1 when |2*high_time - period| <= 2*TOL + 1, computed at WIDTH+1 bits.
- Not defined: no duty logic is built, and duty_ok is driven constant 0.

Test Plan:
- Drive clk_in = ideal /60 (30 high, 30 low) with enable=1 -> the first meas_valid comes after the second rising edge with period=60, high_time=30, freq_ok=1; every subsequent pulse is exactly 60 cycles apart.
- clk_in period 62 (31/31), N_EXP=60, TOL=1 -> period=62, freq_ok=0. Period 59 -> freq_ok=1.
- Hold clk_in low after locking -> err_timeout=1 exactly 240 cycles after the last rise, freq_ok=0, period stays 60. Restart clk_in -> err_timeout clears on the next meas_valid.
- Assert reset low mid-MEASURE (asynchronously, between clk_fpga edges) -> all outputs read 0 immediately. After release, no meas_valid appears until two rises have been seen.
- Drop enable for 5 cycles mid-period, then re-raise -> no meas_valid from the partial period. The next valid period=60 is measured from a fresh ARM.
- With CLK_PERIOD_METER_DUTY_CHECK_EN: 30/30 -> duty_ok=1; 40/20 -> duty_ok=0. Without the macro, duty_ok is constant 0.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Receive-side checker for a divided clock. The incoming slow clock is
//   synchronised into the clk_fpga domain. The checker measures the period
//   and the high time of the slow clock in clk_fpga cycles. It flags a period
//   outside N_EXP +/- TOL, and it flags an input that has stopped toggling.
//
//   Optional feature: define CLK_PERIOD_METER_DUTY_CHECK_EN to build the duty
//   check. When the macro is not defined, duty_ok is tied to 0.
//
// Ports
//   clk_fpga    in   system clock; all logic runs on its rising edge
//   reset       in   asynchronous active-low reset
//   clk_in      in   divided clock under test (asynchronous)
//   enable      in   1 = measure; 0 = return to idle, outputs hold
//   period      out  last measured period, in clk_fpga cycles
//   high_time   out  last measured high time, in clk_fpga cycles
//   meas_valid  out  one-cycle pulse when period/high_time update
//   freq_ok     out  |period - N_EXP| <= TOL for the last measurement
//   err_timeout out  sticky stall flag (cleared by the next measurement)
//   duty_ok     out  |2*high_time - period| <= 2*TOL+1 (0 if not built)
`timescale 1ns/1ps
module clk_period_meter #(
  parameter int WIDTH   = 16,
  parameter int N_EXP   = 60,
  parameter int TOL     = 1,
  parameter int TIMEOUT = 240
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             err_timeout,
  output logic             duty_ok
);

  localparam logic [WIDTH-1:0] NEXP_W = WIDTH'(N_EXP);
  localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] TMO_W  = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             sync_p0, sync_p1, sync_p2;
  logic             rise;
  logic [WIDTH-1:0] tot_cnt, hi_cnt, idle_cnt;
  logic [WIDTH-1:0] per_new;
  logic             meas_evt, tmo_evt, idle_hit;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // ---- stage p0..p2: two-flop synchroniser plus edge-detect flop ----
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= clk_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise     = sync_p1 & ~sync_p2;
  assign per_new  = sat_inc(tot_cnt);   // this cycle closes the period
  assign idle_hit = (sat_inc(idle_cnt) == TMO_W);

  // ---- control: state register and next-state decode ----
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A rise takes priority over a timeout that occurs in the same cycle.
  always_comb begin
    state_nxt = state;
    meas_evt  = 1'b0;
    tmo_evt   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM: begin
          if (rise)          state_nxt = MEASURE;
          else if (idle_hit) tmo_evt   = 1'b1;
        end
        MEASURE: begin
          if (rise) begin
            meas_evt = 1'b1;
          end else if (idle_hit) begin
            tmo_evt   = 1'b1;
            state_nxt = ARM;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- counters: period/high-time accumulators and stall counter ----
  // Counters accumulate only in MEASURE. Every other state, and each
  // completed or abandoned measurement, starts them again from zero.
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      tot_cnt  <= '0;
      hi_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      if (!enable || state != MEASURE || meas_evt || tmo_evt) begin
        tot_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        tot_cnt <= sat_inc(tot_cnt);
        if (sync_p2) hi_cnt <= sat_inc(hi_cnt);
      end
      if (!enable || state == IDLE || rise || tmo_evt) idle_cnt <= '0;
      else                                             idle_cnt <= sat_inc(idle_cnt);
    end
  end

  // ---- outputs: registered results ----
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      freq_ok     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      meas_valid <= meas_evt;
      if (meas_evt) begin
        period      <= per_new;
        high_time   <= hi_cnt;
        freq_ok     <= (abs_diff(per_new, NEXP_W) <= TOL_W);
        err_timeout <= 1'b0;
      end else if (tmo_evt) begin
        err_timeout <= 1'b1;
        freq_ok     <= 1'b0;
      end
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
  localparam logic [WIDTH:0] DUTY_LIM = (WIDTH+1)'(2*TOL+1);

  // One extra bit holds 2*high_time without overflow.
  function automatic logic duty_in_tol(input logic [WIDTH-1:0] hi,
                                       input logic [WIDTH-1:0] per);
    logic [WIDTH:0] twice_hi, per_x, dev;
    twice_hi = {hi, 1'b0};
    per_x    = {1'b0, per};
    dev      = (twice_hi >= per_x) ? twice_hi - per_x : per_x - twice_hi;
    return dev <= DUTY_LIM;
  endfunction

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset)        duty_ok <= 1'b0;
    else if (meas_evt) duty_ok <= duty_in_tol(hi_cnt, per_new);
  end
`else
  assign duty_ok = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;
  localparam int WIDTH   = 16;
  localparam int N_EXP   = 60;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 240;
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic             clk_fpga = 1'b0;
  logic             reset;
  logic             clk_in;
  logic             enable;
  logic [WIDTH-1:0] period, high_time;
  logic             meas_valid, freq_ok, err_timeout, duty_ok;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  clk_period_meter #(
    .WIDTH(WIDTH), .N_EXP(N_EXP), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .clk_in     (clk_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .err_timeout(err_timeout),
    .duty_ok    (duty_ok)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_true(input string name, input bit cond, input int act);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: condition false, observed value %0d at %0t", name, act, $time);
    end
  endtask

  // Slow-clock generator: hi_len cycles high, then lo_len cycles low.
  // It changes only on falling edges of clk_fpga. While run=0 it drives low.
  int hi_len = 30, lo_len = 30, ph = 0;
  bit run = 1'b0;
  initial begin
    clk_in = 1'b0;
    forever begin
      @(negedge clk_fpga);
      if (!run) begin
        clk_in = 1'b0;
        ph     = 0;
      end else begin
        clk_in = (ph < hi_len);
        ph     = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
      end
    end
  end

  // Reference model. The synchronised input is clk_in delayed by the sample
  // chain. Each measurement is described by edge timestamps: the period is
  // the distance between two rise edges. The high time is the difference of
  // a running count of cycles in which the delayed input was high.
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2;
  int mode = M_IDLE, cyc = 0, t_ref = 0, c_prev = 0, cum = 0, hi_mark = 0;
  int per = 0, ht = 0, dv = 0, dd = 0;
  bit d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, rise_m = 1'b0;
  logic [WIDTH-1:0] m_period = '0, m_high = '0;
  bit m_valid = 1'b0, m_freq = 1'b0, m_err = 1'b0, m_duty = 1'b0;

  initial begin
    forever begin
      @(posedge clk_fpga or negedge reset);
      if (!reset) begin
        d0 = 0; d1 = 0; d2 = 0; mode = M_IDLE;
        m_period = '0; m_high = '0;
        m_valid = 0; m_freq = 0; m_err = 0; m_duty = 0;
      end else begin
        rise_m = d1 && !d2;
        cyc++;
        if (d2) cum++;
        m_valid = 1'b0;
        if (!enable) begin
          mode = M_IDLE;
        end else if (mode == M_IDLE) begin
          mode  = M_ARM;
          t_ref = cyc;
        end else if (rise_m) begin
          if (mode == M_MEAS) begin
            per      = cyc - c_prev;
            ht       = cum - hi_mark;
            m_period = (per > 65535) ? 16'hFFFF : per[WIDTH-1:0];
            m_high   = (ht > 65535) ? 16'hFFFF : ht[WIDTH-1:0];
            dv       = (per >= N_EXP) ? per - N_EXP : N_EXP - per;
            dd       = (2 * ht >= per) ? 2 * ht - per : per - 2 * ht;
            m_freq   = (dv <= TOL);
            m_duty   = DUTY_ON && (dd <= 2 * TOL + 1);
            m_err    = 1'b0;
            m_valid  = 1'b1;
          end
          mode    = M_MEAS;
          c_prev  = cyc;
          hi_mark = cum;
          t_ref   = cyc;
        end else if (cyc - t_ref == TIMEOUT) begin
          m_err  = 1'b1;
          m_freq = 1'b0;
          mode   = M_ARM;
          t_ref  = cyc;
        end
        d2 = d1; d1 = d0; d0 = clk_in;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk_fpga) begin
    if (chk_on) begin
      chk("period",      32'(period),      32'(m_period));
      chk("high_time",   32'(high_time),   32'(m_high));
      chk("meas_valid",  32'(meas_valid),  32'(m_valid));
      chk("freq_ok",     32'(freq_ok),     32'(m_freq));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      chk("duty_ok",     32'(duty_ok),     32'(m_duty));
    end
  end

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk_fpga);
      n++;
    end while (!meas_valid && n < max);
    chk("meas_valid arrives", 32'(meas_valid), 32'd1);
  endtask

  task automatic set_shape(input int h, input int l);
    int n;
    hi_len = h;
    lo_len = l;
    for (int i = 0; i < 3; i++) wait_valid(200, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  prev_err;
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk_fpga);
    chk_on = 1'b1;
    repeat (2) @(negedge clk_fpga);
    chk("reset period",      32'(period),      32'd0);
    chk("reset high_time",   32'(high_time),   32'd0);
    chk("reset meas_valid",  32'(meas_valid),  32'd0);
    chk("reset err_timeout", 32'(err_timeout), 32'd0);

    // Ideal /60 clock: first result after the second rise, then every 60 cycles
    reset  = 1'b1;
    enable = 1'b1;
    run    = 1'b1;
    wait_valid(300, n);
    chk("lock period",    32'(period),    32'd60);
    chk("lock high_time", 32'(high_time), 32'd30);
    chk("lock freq_ok",   32'(freq_ok),   32'd1);
    chk("lock duty_ok",   32'(duty_ok),   32'(DUTY_ON));
    wait_valid(100, n);
    chk("pulse spacing 1", 32'(n), 32'd60);
    wait_valid(100, n);
    chk("pulse spacing 2", 32'(n), 32'd60);

    // Off-nominal periods
    set_shape(31, 31);
    chk("p62 period",  32'(period),  32'd62);
    chk("p62 freq_ok", 32'(freq_ok), 32'd0);
    chk("p62 duty_ok", 32'(duty_ok), 32'(DUTY_ON));
    set_shape(30, 29);
    chk("p59 period",    32'(period),    32'd59);
    chk("p59 high_time", 32'(high_time), 32'd30);
    chk("p59 freq_ok",   32'(freq_ok),   32'd1);

    // Skewed duty cycle
    set_shape(40, 20);
    chk("d40 period",    32'(period),    32'd60);
    chk("d40 high_time", 32'(high_time), 32'd40);
    chk("d40 freq_ok",   32'(freq_ok),   32'd1);
    chk("d40 duty_ok",   32'(duty_ok),   32'd0);
    set_shape(30, 30);
    chk("d30 duty_ok",   32'(duty_ok),   32'(DUTY_ON));

    // Stall: err_timeout exactly TIMEOUT cycles after the last rise
    run = 1'b0;
    n   = 0;
    do begin
      @(negedge clk_fpga);
      n++;
    end while (!err_timeout && n < 400);
    chk("timeout latency",    32'(n),       32'd240);
    chk("timeout period",     32'(period),  32'd60);
    chk("timeout freq_ok",    32'(freq_ok), 32'd0);
    repeat (50) @(negedge clk_fpga);
    run = 1'b1;
    n   = 0;
    prev_err = err_timeout;
    do begin
      prev_err = err_timeout;
      @(negedge clk_fpga);
      n++;
    end while (!meas_valid && n < 300);
    chk("restart meas_valid",   32'(meas_valid),  32'd1);
    chk("err held before",      32'(prev_err),    32'd1);
    chk("err cleared on valid", 32'(err_timeout), 32'd0);
    chk("restart period",       32'(period),      32'd60);

    // Enable dropped mid-period: partial period discarded, fresh ARM
    wait_valid(100, n);
    repeat (15) @(negedge clk_fpga);
    enable = 1'b0;
    repeat (5) @(negedge clk_fpga);
    enable = 1'b1;
    wait_valid(300, n);
    chk_true("re-arm delay > 60", n > 60, n);
    chk("re-arm period",    32'(period),    32'd60);
    chk("re-arm high_time", 32'(high_time), 32'd30);

    // Asynchronous reset between clock edges, in the middle of a measurement
    wait_valid(100, n);
    repeat (10) @(negedge clk_fpga);
    #7;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    chk("async period",      32'(period),      32'd0);
    chk("async high_time",   32'(high_time),   32'd0);
    chk("async meas_valid",  32'(meas_valid),  32'd0);
    chk("async freq_ok",     32'(freq_ok),     32'd0);
    chk("async err_timeout", 32'(err_timeout), 32'd0);
    chk("async duty_ok",     32'(duty_ok),     32'd0);
    repeat (3) @(negedge clk_fpga);
    reset = 1'b1;
    repeat (5) @(negedge clk_fpga);
    run = 1'b1;
    wait_valid(300, n);
    chk_true("post-reset needs two rises", n >= 60, n);
    chk("post-reset period", 32'(period), 32'd60);

    repeat (5) @(negedge clk_fpga);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
